game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game-flow controller for TypeRacer. It sits directly upstream of the typing/statistics counter. It decodes single-key commands from the PS/2 keyboard decoder and sequences the SELECT → COUNTDOWN → INGAME → FINISH states. It drives the `state`, `mode` and `value` inputs of the counter and consumes that block's `finish` flag.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: `clk` cycles per second, used for the 1 s tick divider.
- `COUNTDOWN_S`, 3: countdown length in seconds (1..3).
- `RETURN_S`, 10: seconds spent in FINISH before auto-return; only used with `GAME_CTRL_AUTORETURN_EN`.

Ports:
- `clk`  in  1: system clock. One clock only.
- `rst`  in  1: reset. **Synchronous and active-high.**
- `key_down`  in  128: held-key bitmap from the keyboard decoder.
- `last_change`  in  9: scancode of the most recent make or break.
- `key_valid`  in  1: one-cycle strobe marking `last_change` as updated.
- `finish`  in  1: game-over flag from the counter block.
- `state`  out  2: 0 = SELECT, 1 = COUNTDOWN, 2 = INGAME, 3 = FINISH.
- `mode`  out  1: 0 = timed game (`value` is in seconds), 1 = word-count game (`value` is in words).
- `value`  out  7: selected limit.
- `countdown`  out  2: seconds remaining, shown during COUNTDOWN; 0 otherwise.
- `preset`  out  2: current preset index, for the menu display.

## Operation
- Key press: `press` = `key_valid` && `key_down[last_change]` && !`held`.
  - `held` is a register loaded with `key_down[last_change]` every cycle.
  - Auto-repeat makes are therefore ignored. Break codes are never presses.
- Command scancodes:
  - ENTER = 9'h05A
  - ESC = 9'h076
  - M = 9'h03A (mode toggle)
  - W = 9'h01D (next preset)
  - S = 9'h01B (previous preset)
  - All other codes are ignored.
- Preset tables, index 0..3:
  - mode 0: 15, 30, 60, 90.
  - mode 1: 10, 25, 50, 100.
  - `value` = table[`mode`][`preset`], registered.
- SELECT:
  - W: `preset` increments, 3 wraps to 0.
  - S: `preset` decrements, 0 wraps to 3.
  - M: toggles `mode` and forces `preset` = 1.
  - ENTER: go to COUNTDOWN, load `countdown` = COUNTDOWN_S, clear the tick divider.
- COUNTDOWN:
  - Each 1 s tick decrements `countdown`.
  - A tick while `countdown` = 1 goes to INGAME and sets `countdown` = 0.
  - ESC goes to SELECT.
- INGAME:
  - `finish` = 1 goes to FINISH.
  - ESC goes to SELECT.
  - W, S, M and ENTER are ignored.
- FINISH:
  - ENTER or ESC goes to SELECT.
- `mode`, `value` and `preset` are frozen outside SELECT and retain their settings across games.
- Simultaneous events:
  - ESC press and `finish` in the same cycle in INGAME: ESC wins, next state is SELECT.
  - ESC press and a tick in the same cycle in COUNTDOWN: ESC wins.
- Tick divider: a counter 0..CLK_HZ-1 that emits a one-cycle tick on wrap. It runs only in COUNTDOWN (and in FINISH when the macro is defined) and is cleared on every state change.

## Timing
- All outputs are registered. A state change appears on the first `clk` edge after the qualifying `press`, `finish` or tick cycle. Latency is 1 cycle.
- `value` follows `mode`/`preset` with 1 cycle of latency; it is combinational from the registers, then registered.
- Reset values while `rst` = 1 and on the edge after:
  - `state` = 0
  - `mode` = 0
  - `preset` = 1
  - `value` = 30
  - `countdown` = 0
  - divider = 0
  - `held` = 0
- Reset mid-game returns to SELECT with default settings; it overrides every concurrent event.
- COUNTDOWN lasts exactly COUNTDOWN_S × CLK_HZ cycles from the ENTER edge to `state` = 2.
- The counter block restarts its timers while `state` = 0. It therefore sees `state` = 0 for at least one cycle between games.

## Configuration
- `GAME_CTRL_AUTORETURN_EN` defined:
  - FINISH runs the tick divider and a seconds counter.
  - After RETURN_S ticks the block goes to SELECT automatically.
  - ENTER or ESC still returns immediately.
- Undefined: FINISH is held until ENTER or ESC. The divider is idle in FINISH and the seconds counter is not built.

## Test plan
For all scenarios: CLK_HZ = 10, COUNTDOWN_S = 3, RETURN_S = 2.
1. Reset, then three W presses, then M → `preset` sequence 2, 3, 0; `value` sequence 60, 90, 15; after M: `mode` = 1, `preset` = 1, `value` = 25.
2. ENTER in SELECT → `state` = 1, `countdown` = 3 → 2 → 1 at 10-cycle intervals; `state` = 2 exactly 30 cycles after the ENTER edge.
3. Hold W with `key_valid` pulsed on 5 consecutive make strobes → `preset` advances once only.
4. INGAME, assert `finish` together with an ESC press → `state` = 0. Repeat with `finish` alone → `state` = 3, then ENTER → 0.
5. `rst` = 1 for one cycle during COUNTDOWN (`countdown` = 2) → next edge: `state` = 0, `countdown` = 0, `value` = 30, `mode` = 0.
6. With `GAME_CTRL_AUTORETURN_EN` defined, reach FINISH, press nothing → `state` = 0 after 20 cycles. Without the macro → `state` stays 3 for 1000 cycles.

Source files
------------

// File: rtl/game_ctrl.sv
// TypeRacer game-flow controller: SELECT -> COUNTDOWN -> INGAME -> FINISH.
// Optional GAME_CTRL_AUTORETURN_EN: FINISH returns to SELECT after RETURN_S seconds.
module game_ctrl #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int COUNTDOWN_S = 3,
    parameter int RETURN_S    = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    input  logic         finish,
    output logic [1:0]   state,
    output logic         mode,
    output logic [6:0]   value,
    output logic [1:0]   countdown,
    output logic [1:0]   preset
);

    localparam logic [1:0] S_SELECT    = 2'd0;
    localparam logic [1:0] S_COUNTDOWN = 2'd1;
    localparam logic [1:0] S_INGAME    = 2'd2;
    localparam logic [1:0] S_FINISH    = 2'd3;

    localparam logic [8:0] K_ENTER = 9'h05A;
    localparam logic [8:0] K_ESC   = 9'h076;
    localparam logic [8:0] K_M     = 9'h03A;
    localparam logic [8:0] K_W     = 9'h01D;
    localparam logic [8:0] K_S     = 9'h01B;

    localparam int               DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
    localparam logic [1:0]       CD_LOAD = 2'(COUNTDOWN_S);

    if (CLK_HZ < 1 || COUNTDOWN_S < 1 || COUNTDOWN_S > 3 || RETURN_S < 1) begin : g_bad_param
        $error("game_ctrl: parameter out of range");
    end

    function automatic logic [6:0] preset_value(input logic m, input logic [1:0] p);
        logic [6:0] v;
        case ({m, p})
            3'b000:  v = 7'd15;
            3'b001:  v = 7'd30;
            3'b010:  v = 7'd60;
            3'b011:  v = 7'd90;
            3'b100:  v = 7'd10;
            3'b101:  v = 7'd25;
            3'b110:  v = 7'd50;
            default: v = 7'd100;
        endcase
        return v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [1:0]       preset_q, preset_d;
    logic [6:0]       value_q, value_d;
    logic [1:0]       cd_q, cd_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             held_q, held_d;

    // Scancodes above the bitmap range (extended codes) never count as held keys.
    logic key_bit, press;
    assign key_bit = (last_change < 9'd128) ? key_down[last_change[6:0]] : 1'b0;
    assign press   = key_valid && key_bit && !held_q;
    assign held_d  = key_bit;

    logic cmd_enter, cmd_esc, cmd_m, cmd_w, cmd_s;
    assign cmd_enter = press && (last_change == K_ENTER);
    assign cmd_esc   = press && (last_change == K_ESC);
    assign cmd_m     = press && (last_change == K_M);
    assign cmd_w     = press && (last_change == K_W);
    assign cmd_s     = press && (last_change == K_S);

    logic div_run, tick;
`ifdef GAME_CTRL_AUTORETURN_EN
    localparam int               SEC_W    = (RETURN_S > 1) ? $clog2(RETURN_S) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(RETURN_S - 1);
    logic [SEC_W-1:0] sec_q, sec_d;
    assign div_run = (state_q == S_COUNTDOWN) || (state_q == S_FINISH);
`else
    assign div_run = (state_q == S_COUNTDOWN);
`endif
    assign tick = div_run && (div_q == DIV_MAX);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        preset_d = preset_q;
        cd_d     = cd_q;
        value_d  = preset_value(mode_q, preset_q);
`ifdef GAME_CTRL_AUTORETURN_EN
        sec_d    = '0;
`endif
        case (state_q)
            S_SELECT: begin
                if (cmd_w) begin
                    preset_d = preset_q + 2'd1;
                end else if (cmd_s) begin
                    preset_d = preset_q - 2'd1;
                end else if (cmd_m) begin
                    mode_d   = ~mode_q;
                    preset_d = 2'd1;
                end else if (cmd_enter) begin
                    state_d = S_COUNTDOWN;
                    cd_d    = CD_LOAD;
                end
            end
            S_COUNTDOWN: begin
                if (cmd_esc) begin
                    state_d = S_SELECT;
                    cd_d    = 2'd0;
                end else if (tick) begin
                    if (cd_q == 2'd1) begin
                        state_d = S_INGAME;
                        cd_d    = 2'd0;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end
            end
            S_INGAME: begin
                if (cmd_esc) begin
                    state_d = S_SELECT;
                end else if (finish) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                if (cmd_enter || cmd_esc) begin
                    state_d = S_SELECT;
                end
`ifdef GAME_CTRL_AUTORETURN_EN
                else if (tick) begin
                    if (sec_q == SEC_LAST) begin
                        state_d = S_SELECT;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end else begin
                    sec_d = sec_q;
                end
`endif
            end
        endcase

        // Divider restarts from zero on any state change so every phase gets whole seconds.
        if (div_run && (state_d == state_q) && !tick) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_SELECT;
            mode_q   <= 1'b0;
            preset_q <= 2'd1;
            value_q  <= 7'd30;
            cd_q     <= 2'd0;
            div_q    <= '0;
            held_q   <= 1'b0;
`ifdef GAME_CTRL_AUTORETURN_EN
            sec_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            preset_q <= preset_d;
            value_q  <= value_d;
            cd_q     <= cd_d;
            div_q    <= div_d;
            held_q   <= held_d;
`ifdef GAME_CTRL_AUTORETURN_EN
            sec_q    <= sec_d;
`endif
        end
    end

    assign state     = state_q;
    assign mode      = mode_q;
    assign preset    = preset_q;
    assign value     = value_q;
    assign countdown = cd_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random key/finish traffic,
// every cycle compared against a time-based behavioural model.
module tb_game_ctrl;

    localparam int CLK_HZ      = 10;
    localparam int COUNTDOWN_S = 3;
    localparam int RETURN_S    = 2;

    localparam logic [8:0] K_ENTER = 9'h05A;
    localparam logic [8:0] K_ESC   = 9'h076;
    localparam logic [8:0] K_M     = 9'h03A;
    localparam logic [8:0] K_W     = 9'h01D;
    localparam logic [8:0] K_S     = 9'h01B;

`ifdef GAME_CTRL_AUTORETURN_EN
    localparam bit AUTORET = 1'b1;
`else
    localparam bit AUTORET = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         finish;
    logic [1:0]   state;
    logic         mode;
    logic [6:0]   value;
    logic [1:0]   countdown;
    logic [1:0]   preset;

    game_ctrl #(
        .CLK_HZ(CLK_HZ),
        .COUNTDOWN_S(COUNTDOWN_S),
        .RETURN_S(RETURN_S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_down(key_down),
        .last_change(last_change),
        .key_valid(key_valid),
        .finish(finish),
        .state(state),
        .mode(mode),
        .value(value),
        .countdown(countdown),
        .preset(preset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: settings as plain integers, timing as elapsed cycles in state.
    int tbl0[4] = '{15, 30, 60, 90};
    int tbl1[4] = '{10, 25, 50, 100};
    int m_state = 0, m_mode = 0, m_preset = 1, m_value = 30, m_cd = 0, m_elapsed = 0;
    bit m_held = 1'b0;

    function automatic int table_val(input int md, input int p);
        return (md == 0) ? tbl0[p] : tbl1[p];
    endfunction

    task automatic model_step();
        bit cur, press;
        int nv;
        cur   = (last_change < 9'd128) ? key_down[last_change[6:0]] : 1'b0;
        press = key_valid && cur && !m_held;
        if (rst) begin
            m_state = 0; m_mode = 0; m_preset = 1; m_value = 30;
            m_cd = 0; m_elapsed = 0; m_held = 1'b0;
            return;
        end
        m_held = cur;
        nv = table_val(m_mode, m_preset);
        case (m_state)
            0: if (press) begin
                if (last_change == K_W) m_preset = (m_preset + 1) % 4;
                else if (last_change == K_S) m_preset = (m_preset + 3) % 4;
                else if (last_change == K_M) begin m_mode = 1 - m_mode; m_preset = 1; end
                else if (last_change == K_ENTER) begin m_state = 1; m_cd = COUNTDOWN_S; m_elapsed = 0; end
            end
            1: if (press && last_change == K_ESC) begin
                m_state = 0; m_cd = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == COUNTDOWN_S * CLK_HZ) begin m_state = 2; m_cd = 0; end
                else m_cd = COUNTDOWN_S - m_elapsed / CLK_HZ;
            end
            2: if (press && last_change == K_ESC) m_state = 0;
               else if (finish) begin m_state = 3; m_elapsed = 0; end
            default: if (press && (last_change == K_ENTER || last_change == K_ESC)) m_state = 0;
                else if (AUTORET) begin
                    m_elapsed++;
                    if (m_elapsed == RETURN_S * CLK_HZ) m_state = 0;
                end
        endcase
        m_value = nv;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("state", int'(state), m_state);
        check("mode", int'(mode), m_mode);
        check("preset", int'(preset), m_preset);
        check("value", int'(value), m_value);
        check("countdown", int'(countdown), m_cd);
    endtask

    task automatic idle(input int n);
        key_valid = 1'b0; finish = 1'b0; rst = 1'b0;
        repeat (n) step();
    endtask

    task automatic press_key(input logic [8:0] c, input bit fin);
        if (c < 9'd128) key_down[c[6:0]] = 1'b1;
        last_change = c; key_valid = 1'b1; finish = fin;
        step();
        key_valid = 1'b0; finish = 1'b0;
    endtask

    task automatic release_key(input logic [8:0] c);
        if (c < 9'd128) key_down[c[6:0]] = 1'b0;
        last_change = c; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic start_game();
        press_key(K_ENTER, 1'b0);
        release_key(K_ENTER);
        idle(COUNTDOWN_S * CLK_HZ - 1);
    endtask

    initial begin
        logic [8:0] code;
        int r, k;
        rst = 1'b1; key_down = '0; last_change = '0; key_valid = 1'b0; finish = 1'b0;
        step();
        step();
        check("rst_state", int'(state), 0);
        check("rst_value", int'(value), 30);
        check("rst_preset", int'(preset), 1);
        rst = 1'b0;
        idle(2);

        // Preset stepping and mode toggle
        press_key(K_W, 1'b0);   check("t1_preset_a", int'(preset), 2);
        release_key(K_W);       check("t1_value_a", int'(value), 60);
        press_key(K_W, 1'b0);   check("t1_preset_b", int'(preset), 3);
        release_key(K_W);       check("t1_value_b", int'(value), 90);
        press_key(K_W, 1'b0);   check("t1_preset_c", int'(preset), 0);
        release_key(K_W);       check("t1_value_c", int'(value), 15);
        press_key(K_M, 1'b0);   check("t1_mode", int'(mode), 1);
                                check("t1_preset_m", int'(preset), 1);
        release_key(K_M);       check("t1_value_m", int'(value), 25);
        press_key(K_S, 1'b0);   check("t1_preset_s", int'(preset), 0);
        release_key(K_S);
        press_key(K_S, 1'b0);   check("t1_preset_wrap", int'(preset), 3);
        release_key(K_S);
        press_key(K_W, 1'b0);
        release_key(K_W);
        press_key(K_W, 1'b0);
        release_key(K_W);

        // Auto-repeat makes while W is held count once
        key_down[K_W[6:0]] = 1'b1; last_change = K_W; key_valid = 1'b1;
        repeat (5) step();
        key_valid = 1'b0;
        check("t3_preset", int'(preset), 2);
        release_key(K_W);       check("t3_value", int'(value), 50);

        // Countdown timing
        press_key(K_ENTER, 1'b0);
        check("t2_state_e", int'(state), 1);
        check("t2_cd_e", int'(countdown), 3);
        release_key(K_ENTER);
        idle(8);  check("t2_cd_9", int'(countdown), 3);
        idle(1);  check("t2_cd_10", int'(countdown), 2);
        idle(9);  check("t2_cd_19", int'(countdown), 2);
        idle(1);  check("t2_cd_20", int'(countdown), 1);
        idle(9);  check("t2_state_29", int'(state), 1);
        idle(1);  check("t2_state_30", int'(state), 2);
                  check("t2_cd_30", int'(countdown), 0);
        press_key(K_W, 1'b0);   check("t2_frozen", int'(preset), 2);
        release_key(K_W);

        // ESC beats finish; finish alone; ENTER leaves FINISH
        press_key(K_ESC, 1'b1); check("t4_esc_wins", int'(state), 0);
        release_key(K_ESC);
        start_game();           check("t4_ingame", int'(state), 2);
        finish = 1'b1; step(); finish = 1'b0;
        check("t4_finish", int'(state), 3);
        press_key(K_ENTER, 1'b0); check("t4_enter", int'(state), 0);
        release_key(K_ENTER);

        // Reset mid-countdown
        press_key(K_ENTER, 1'b0);
        release_key(K_ENTER);
        idle(12);               check("t5_cd", int'(countdown), 2);
        rst = 1'b1; step(); rst = 1'b0;
        check("t5_state", int'(state), 0);
        check("t5_cd0", int'(countdown), 0);
        check("t5_value", int'(value), 30);
        check("t5_mode", int'(mode), 0);
        idle(1);                check("t5_value_hold", int'(value), 30);

        // FINISH dwell
        start_game();
        finish = 1'b1; step(); finish = 1'b0;
        check("t6_finish", int'(state), 3);
`ifdef GAME_CTRL_AUTORETURN_EN
        idle(RETURN_S * CLK_HZ - 1); check("t6_before", int'(state), 3);
        idle(1);                     check("t6_return", int'(state), 0);
`else
        idle(1000);                  check("t6_held", int'(state), 3);
        press_key(K_ESC, 1'b0);      check("t6_esc", int'(state), 0);
        release_key(K_ESC);
`endif

        // Random traffic
        repeat (20000) begin
            r = $urandom_range(0, 99);
            rst = ($urandom_range(0, 999) == 0);
            finish = ($urandom_range(0, 29) == 0);
            if (r < 10) begin
                k = $urandom_range(0, 9);
                case (k)
                    0, 1, 2: code = K_ENTER;
                    3:       code = K_ESC;
                    4, 5:    code = K_W;
                    6:       code = K_S;
                    7:       code = K_M;
                    8:       code = 9'h01C;
                    default: code = 9'h15A;
                endcase
                if (code < 9'd128) key_down[code[6:0]] = ($urandom_range(0, 9) < 7);
                last_change = code;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            step();
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
